// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
//   Bundle of the MEM/WB writeback signals, the two ID-stage read ports and
//   the writeback/debug outputs of wb_regfile.
//
//   Modports
//     master : the pipeline side. It drives the MEM/WB fields and the read
//              addresses, and it observes the read data, wb_data, wb_valid
//              and wb_count.
//     slave  : the register file side (wb_regfile).
//
//   Signals
//     mem_wb_regwrite     1     commit request for this cycle
//     mem_wb_memtoreg     1     1 = load data, 0 = ALU result
//     mem_wb_register_rd  AW    destination register
//     result_mem_wb       XLEN  ALU result
//     read_data_mem_wb    XLEN  load data
//     rs1_addr, rs2_addr  AW    read port addresses
//     rs1_data, rs2_data  XLEN  read port data (combinational)
//     wb_data             XLEN  selected writeback value (combinational)
//     wb_valid            1     a commit happens on the next edge
//     wb_count            32    committed-write counter (registered)
// ---------------------------------------------------------------------------
interface wb_regfile_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            mem_wb_regwrite;
  logic            mem_wb_memtoreg;
  logic [AW-1:0]   mem_wb_register_rd;
  logic [XLEN-1:0] result_mem_wb;
  logic [XLEN-1:0] read_data_mem_wb;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] wb_data;
  logic            wb_valid;
  logic [31:0]     wb_count;

  modport master (
    output mem_wb_regwrite, mem_wb_memtoreg, mem_wb_register_rd,
           result_mem_wb, read_data_mem_wb, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, wb_valid, wb_count
  );

  modport slave (
    input  mem_wb_regwrite, mem_wb_memtoreg, mem_wb_register_rd,
           result_mem_wb, read_data_mem_wb, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, wb_valid, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Writeback stage of the pipeline together with the integer register file.
//   It selects the writeback value (ALU result or load data), commits it to
//   the register array on the rising clock edge, serves two combinational
//   read ports to ID, exports the writeback value for EX forwarding, and
//   counts committed writes.
//
//   Ports
//     clk    in   system clock, all state updates on posedge
//     rst_n  in   asynchronous reset, active low; clears the array and
//                 wb_count at once
//     bus    wb_regfile_if.slave (see rtl/wb_regfile_if.sv)
//
//   Build option
//     WB_BYPASS_EN : when defined, a read of the register being written in
//                    the same cycle returns wb_data (write-through). When
//                    undefined, the read returns the old array contents and
//                    the hazard unit has to stall ID for one cycle.
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_regfile_if.slave bus
);

  logic [XLEN-1:0] regs [NREG];
  logic [31:0]     count_q;
  logic [XLEN-1:0] wb_data;
  logic            wb_valid;

  // Writeback mux: purely combinational, no added latency.
  assign wb_data = bus.mem_wb_memtoreg ? bus.read_data_mem_wb : bus.result_mem_wb;

  // Commit qualifier. There is no handshake on this interface: whenever
  // wb_valid is high at a rising edge the write is committed and counted;
  // a destination of x0 is never a commit.
  assign wb_valid = bus.mem_wb_regwrite && (bus.mem_wb_register_rd != '0);

  assign bus.wb_data  = wb_data;
  assign bus.wb_valid = wb_valid;
  assign bus.wb_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      count_q <= '0;
    end else if (wb_valid) begin
      regs[bus.mem_wb_register_rd] <= wb_data;
      count_q                      <= count_q + 32'd1;  // wraps silently
    end
  end

  // One read port. x0 is forced to zero here so that regs[0] never matters.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    if (addr == '0) begin
      val = '0;
`ifdef WB_BYPASS_EN
    end else if (wb_valid && (addr == bus.mem_wb_register_rd)) begin
      // Write-through: hand the in-flight value to ID in the same cycle.
      val = wb_data;
`endif
    end else begin
      val = regs[addr];
    end
    return val;
  endfunction

  assign bus.rs1_data = read_port(bus.rs1_addr);
  assign bus.rs2_data = read_port(bus.rs2_addr);

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam int XLEN = 32;
  localparam int AW   = 5;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // signal selectors used by the scoreboard
  localparam int S_RS1   = 0;
  localparam int S_RS2   = 1;
  localparam int S_WBD   = 2;
  localparam int S_WBV   = 3;
  localparam int S_COUNT = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.XLEN(XLEN), .AW(AW)) bus ();

  wb_regfile #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // mem_wb_regwrite must never be X/Z once out of reset
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(bus.mem_wb_regwrite))
        else $error("mem_wb_regwrite unknown");
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          sig_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;
  event        chk_ev;

  initial begin : monitor
    logic [31:0] e;
    logic [31:0] a;
    int          s;
    string       n;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        s = sig_q.pop_front();
        n = name_q.pop_front();
        case (s)
          S_RS1:   a = bus.rs1_data;
          S_RS2:   a = bus.rs2_data;
          S_WBD:   a = bus.wb_data;
          S_WBV:   a = {31'b0, bus.wb_valid};
          default: a = bus.wb_count;
        endcase
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got=%h expected=%h (t=%0t)", n, a, e, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_val(input int sig, input logic [31:0] exp, input string name);
    sig_q.push_back(sig);
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // hand the queued expectations to the monitor and make sure it drained
  task automatic fire();
    -> chk_ev;
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
      exp_q.delete();
      sig_q.delete();
      name_q.delete();
    end
  endtask

  task automatic drive_wr(input logic we, input logic m2r, input logic [AW-1:0] rd,
                          input logic [31:0] res, input logic [31:0] ld);
    bus.mem_wb_regwrite    = we;
    bus.mem_wb_memtoreg    = m2r;
    bus.mem_wb_register_rd = rd;
    bus.result_mem_wb      = res;
    bus.read_data_mem_wb   = ld;
  endtask

  task automatic set_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
    #1;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive_wr(1'b0, 1'b0, '0, '0, '0);
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;

    // reset state
    tick();
    set_rd(5'd1, 5'd31);
    expect_val(S_RS1, 32'h0, "reset_rs1");
    expect_val(S_RS2, 32'h0, "reset_rs2");
    expect_val(S_COUNT, 32'h0, "reset_count");
    fire();
    tick();
    rst_n = 1'b1;

    // fill every register with random data, half ALU, half load
    for (int r = 1; r < 32; r++) begin
      drive_wr(1'b1, r[0], r[AW-1:0], $urandom, $urandom);
      tick();
    end
    drive_wr(1'b0, 1'b0, '0, '0, '0);
    #1;
    expect_val(S_COUNT, 32'd31, "fill_count");
    fire();

    // test 1: reset held 3 cycles clears everything
    rst_n = 1'b0;
    #1;
    // wb_data / wb_valid still follow their inputs during reset
    drive_wr(1'b1, 1'b1, 5'd3, 32'h0000_0001, 32'h5A5A_5A5A);
    #1;
    expect_val(S_WBD, 32'h5A5A_5A5A, "rst_wb_data");
    expect_val(S_WBV, 32'h1, "rst_wb_valid");
    fire();
    drive_wr(1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    for (int a = 0; a < 32; a++) begin
      set_rd(a[AW-1:0], 5'(31 - a));
      expect_val(S_RS1, 32'h0, "rst_all_rs1");
      expect_val(S_RS2, 32'h0, "rst_all_rs2");
      fire();
    end
    expect_val(S_COUNT, 32'h0, "rst_all_count");
    fire();
    tick();
    rst_n = 1'b1;

    // test 2: ALU write to x5
    drive_wr(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h5555_5555);
    #1;
    expect_val(S_WBD, 32'hDEAD_BEEF, "alu_wb_data");
    expect_val(S_WBV, 32'h1, "alu_wb_valid");
    fire();
    tick();
    drive_wr(1'b0, 1'b0, '0, '0, '0);
    set_rd(5'd5, 5'd0);
    expect_val(S_RS1, 32'hDEAD_BEEF, "alu_rs1");
    expect_val(S_RS2, 32'h0, "alu_rs2_x0");
    expect_val(S_COUNT, 32'd1, "alu_count");
    fire();

    // test 3: load write to x31
    drive_wr(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h1234_5678);
    #1;
    expect_val(S_WBD, 32'h1234_5678, "load_wb_data");
    fire();
    tick();
    drive_wr(1'b0, 1'b0, '0, '0, '0);
    set_rd(5'd5, 5'd31);
    expect_val(S_RS2, 32'h1234_5678, "load_rs2");
    expect_val(S_RS1, 32'hDEAD_BEEF, "load_rs1_keep");
    expect_val(S_COUNT, 32'd2, "load_count");
    fire();

    // test 4a: write to x0 is dropped
    drive_wr(1'b1, 1'b0, 5'd0, 32'hAAAA_AAAA, 32'h0);
    #1;
    expect_val(S_WBV, 32'h0, "x0_wb_valid");
    expect_val(S_WBD, 32'hAAAA_AAAA, "x0_wb_data");
    fire();
    tick();
    drive_wr(1'b0, 1'b0, '0, '0, '0);
    set_rd(5'd0, 5'd0);
    expect_val(S_RS1, 32'h0, "x0_rs1");
    expect_val(S_COUNT, 32'd2, "x0_count");
    fire();

    // test 4b: regwrite=0 leaves x7 alone
    drive_wr(1'b1, 1'b0, 5'd7, 32'h0000_0070, 32'h0);
    tick();
    drive_wr(1'b0, 1'b1, 5'd7, 32'h0000_0BAD, 32'h0000_0BAD);
    #1;
    expect_val(S_WBV, 32'h0, "dis_wb_valid");
    fire();
    tick();
    set_rd(5'd7, 5'd7);
    expect_val(S_RS1, 32'h0000_0070, "dis_rs1");
    expect_val(S_COUNT, 32'd3, "dis_count");
    fire();

    // test 5: same-cycle read and write of x9
    drive_wr(1'b1, 1'b0, 5'd9, 32'h0000_0011, 32'h0);
    tick();
    drive_wr(1'b1, 1'b0, 5'd9, 32'h0000_CAFE, 32'h0);
    set_rd(5'd9, 5'd9);
    expect_val(S_RS1, BYP ? 32'h0000_CAFE : 32'h0000_0011, "same_rs1");
    expect_val(S_RS2, BYP ? 32'h0000_CAFE : 32'h0000_0011, "same_rs2");
    fire();
    // a different register is never bypassed
    set_rd(5'd5, 5'd9);
    expect_val(S_RS1, 32'hDEAD_BEEF, "same_other_rs1");
    fire();
    tick();
    drive_wr(1'b0, 1'b0, '0, '0, '0);
    set_rd(5'd9, 5'd9);
    expect_val(S_RS1, 32'h0000_CAFE, "after_rs1");
    expect_val(S_RS2, 32'h0000_CAFE, "after_rs2");
    expect_val(S_COUNT, 32'd5, "after_count");
    fire();

    // test 6: async reset pulse while a write is pending
    drive_wr(1'b1, 1'b0, 5'd12, 32'h0000_1234, 32'h0);
    #1;
    rst_n = 1'b0;
    set_rd(5'd5, 5'd9);
    expect_val(S_RS1, 32'h0, "async_rs1");
    expect_val(S_RS2, 32'h0, "async_rs2");
    expect_val(S_COUNT, 32'h0, "async_count");
    fire();
    tick();               // masked edge
    rst_n = 1'b1;
    drive_wr(1'b0, 1'b0, '0, '0, '0);
    set_rd(5'd12, 5'd0);
    expect_val(S_RS1, 32'h0, "masked_rs1");
    expect_val(S_COUNT, 32'h0, "masked_count");
    fire();

    // first edge after reset release writes normally
    drive_wr(1'b1, 1'b1, 5'd12, 32'h0, 32'h0000_4321);
    tick();
    drive_wr(1'b0, 1'b0, '0, '0, '0);
    set_rd(5'd12, 5'd12);
    expect_val(S_RS1, 32'h0000_4321, "post_rs1");
    expect_val(S_COUNT, 32'd1, "post_count");
    fire();

    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
